// File: rtl/pio_out_pulse.sv
// Avalon-MM PIO output port with set/clear/toggle aliases and a self-timed
// pulse engine that inverts masked output bits for a programmed number of clocks.
module pio_out_pulse #(
  parameter int unsigned                 DATA_WIDTH  = 16,
  parameter int unsigned                 CNT_WIDTH   = 24,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  typedef enum logic [2:0] {
    A_DATA   = 3'd0,
    A_SET    = 3'd1,
    A_CLR    = 3'd2,
    A_TOGGLE = 3'd3,
    A_MASK   = 3'd4,
    A_PULSE  = 3'd5,
    A_STATUS = 3'd6,
    A_RSVD   = 3'd7
  } reg_addr_e;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] pulse_mask;
  logic [CNT_WIDTH-1:0]  pulse_cnt;
  logic [DATA_WIDTH-1:0] wd;
  logic                  wr_en;
  logic [31:0]           rd_mux;
  logic                  unused_wd_bits;

  assign wr_en          = chipselect & ~write_n;
  assign wd             = writedata[DATA_WIDTH-1:0];
  assign unused_wd_bits = ^writedata;

  assign pulse_busy = |pulse_cnt;
  assign out_port   = data_reg ^ (pulse_mask & {DATA_WIDTH{pulse_busy}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg   <= RESET_VALUE;
      pulse_mask <= '0;
    end else if (wr_en) begin
      case (address)
        A_DATA:   data_reg   <= wd;
        A_SET:    data_reg   <= data_reg | wd;
        A_CLR:    data_reg   <= data_reg & ~wd;
        A_TOGGLE: data_reg   <= data_reg ^ wd;
        A_MASK:   pulse_mask <= wd;
        default:  ;
      endcase
    end
  end

  // A PULSE write wins over the decrement, so a restart on the last count still takes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_cnt <= '0;
    end else if (wr_en && (address == A_PULSE)) begin
      pulse_cnt <= writedata[CNT_WIDTH-1:0];
    end else if (pulse_busy) begin
      pulse_cnt <= pulse_cnt - CNT_WIDTH'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      A_DATA:   rd_mux = 32'(data_reg);
      A_MASK:   rd_mux = 32'(pulse_mask);
      A_PULSE:  rd_mux = 32'(pulse_cnt);
      A_STATUS: rd_mux = {31'd0, pulse_busy};
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Directed bench for pio_out_pulse: register map, atomic ops, pulse timing,
// restart/abort, concurrency with base writes, async reset and width handling.
module tb_pio_out_pulse;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic        pulse_busy;

  int unsigned total;
  int unsigned bad;

  pio_out_pulse #(
    .DATA_WIDTH (16),
    .CNT_WIDTH  (24),
    .RESET_VALUE(16'h0000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .pulse_busy(pulse_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge and
  // the task returns at the following falling edge with the bus idle.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    @(negedge clk);
    chk(tag, readdata, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // 1. reset and DATA write
    #2;
    chk("rst_out", 32'(out_port), 32'h0000);
    chk("rst_rd", readdata, 32'h0);
    chk("rst_busy", 32'(pulse_busy), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    wr(3'd0, 32'hFFFF_A5A5);
    chk("data_out", 32'(out_port), 32'hA5A5);
    chk("data_no_bypass", readdata, 32'h0000_0000);
    rdchk("data_rd", 3'd0, 32'h0000_A5A5);

    // 2. atomic ops
    wr(3'd1, 32'h0000_000F);
    chk("set_out", 32'(out_port), 32'hA5AF);
    wr(3'd2, 32'h0000_A000);
    chk("clr_out", 32'(out_port), 32'h05AF);
    wr(3'd3, 32'hFFFF_00FF);
    chk("tog_out", 32'(out_port), 32'h0550);
    rdchk("rd_set", 3'd1, 32'h0);
    rdchk("rd_clr", 3'd2, 32'h0);
    rdchk("rd_tog", 3'd3, 32'h0);
    rdchk("rd_data2", 3'd0, 32'h0000_0550);

    // 3. basic pulse of 5
    wr(3'd0, 32'h0);
    wr(3'd4, 32'h1);
    rdchk("mask_rd", 3'd4, 32'h1);
    wr(3'd5, 32'd5);
    chk("p5_out0", 32'(out_port), 32'h0001);
    chk("p5_busy0", 32'(pulse_busy), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      rdchk($sformatf("p5_cnt%0d", i), 3'd5, 32'(6 - i));
      chk($sformatf("p5_out%0d", i), 32'(out_port), (i < 5) ? 32'h1 : 32'h0);
      chk($sformatf("p5_busy%0d", i), 32'(pulse_busy), (i < 5) ? 32'h1 : 32'h0);
    end
    rdchk("p5_cnt_end", 3'd5, 32'd0);
    rdchk("p5_status", 3'd6, 32'd0);

    // 4. restart at remaining=2
    wr(3'd5, 32'd10);
    for (int i = 0; i < 8; i++) tick();
    chk("rs_busy_pre", 32'(pulse_busy), 32'h1);
    wr(3'd5, 32'd4);
    chk("rs_out0", 32'(out_port), 32'h0001);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk($sformatf("rs_out%0d", j), 32'(out_port), (j < 4) ? 32'h1 : 32'h0);
    end
    // restart on the final-count edge
    wr(3'd5, 32'd1);
    wr(3'd5, 32'd3);
    chk("rs_last_busy", 32'(pulse_busy), 32'h1);
    rdchk("rs_last_cnt", 3'd5, 32'd3);
    tick();
    tick();
    chk("rs_last_done", 32'(pulse_busy), 32'h0);

    // abort with PULSE=0
    wr(3'd5, 32'd7);
    rdchk("ab_status1", 3'd6, 32'd1);
    wr(3'd5, 32'd0);
    chk("ab_out", 32'(out_port), 32'h0000);
    chk("ab_busy", 32'(pulse_busy), 32'h0);
    rdchk("ab_status0", 3'd6, 32'd0);

    // 5. base write during pulse
    wr(3'd5, 32'd6);
    wr(3'd0, 32'h0000_00F0);
    chk("cc_out0", 32'(out_port), 32'h00F1);
    for (int i = 0; i < 4; i++) tick();
    chk("cc_out_last", 32'(out_port), 32'h00F1);
    tick();
    chk("cc_out_exp", 32'(out_port), 32'h00F0);
    // mask change mid-pulse keeps remaining count
    wr(3'd5, 32'd4);
    wr(3'd4, 32'h3);
    chk("mk_out", 32'(out_port), 32'h00F3);
    rdchk("mk_cnt", 3'd5, 32'd3);
    // asynchronous reset mid-pulse
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out", 32'(out_port), 32'h0000);
    chk("ar_busy", 32'(pulse_busy), 32'h0);
    chk("ar_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 6. width handling and reserved address
    wr(3'd4, 32'h1);
    wr(3'd5, 32'hFF00_0003);
    rdchk("wd_cnt", 3'd5, 32'd3);
    tick();
    tick();
    chk("wd_done", 32'(pulse_busy), 32'h0);
    rdchk("wd_nowrap", 3'd5, 32'd0);
    wr(3'd5, 32'h00FF_FFFF);
    rdchk("wd_max", 3'd5, 32'h00FF_FFFF);
    wr(3'd5, 32'd0);
    wr(3'd0, 32'h0000_1234);
    wr(3'd7, 32'hFFFF_FFFF);
    chk("r7_out", 32'(out_port), 32'h1234);
    chk("r7_busy", 32'(pulse_busy), 32'h0);
    rdchk("r7_rd", 3'd7, 32'h0);
    rdchk("r7_data", 3'd0, 32'h0000_1234);
    rdchk("r7_mask", 3'd4, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_out_pulse.md
Name: pio_out_pulse

Overview:
- Avalon-MM slave PIO output port; the write-side counterpart of the PIO input block.
- Holds an output data register with atomic set/clear/toggle addresses.
- Adds a hardware pulse engine: it inverts masked output bits for exactly N clocks, then reverts automatically.
- Sits on the MCU data bus; out_port drives board LEDs/strobes.

Parameters:
DATA_WIDTH, 16, width of out_port and data/mask registers
CNT_WIDTH, 24, width of pulse length counter
RESET_VALUE, 0, reset value of data register (DATA_WIDTH bits)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
writedata  input  32  write data
readdata  output  32  registered read data, zero-extended
out_port  output  DATA_WIDTH  output pins
pulse_busy  output  1  high while pulse engine active

Behaviour:
- Reset (async, reset_n=0), all values immediately:
  - data_reg=RESET_VALUE, pulse_mask=0, pulse_cnt=0, readdata=0.
  - Therefore out_port=RESET_VALUE and pulse_busy=0.
- Register map; writes use writedata[DATA_WIDTH-1:0] unless noted, upper bits ignored:
  - 0 DATA: RW; write loads data_reg.
  - 1 SET: W; data_reg |= wd.
  - 2 CLR: W; data_reg &= ~wd.
  - 3 TOGGLE: W; data_reg ^= wd.
  - 4 MASK: RW; write loads pulse_mask.
  - 5 PULSE: W of writedata[CNT_WIDTH-1:0] loads pulse_cnt; read returns remaining pulse_cnt.
  - 6 STATUS: R; bit0=pulse_busy, other bits 0.
  - 7: reserved; reads 0, writes ignored.
  - Reads of 1, 2, 3 return 0.
- Write timing:
  - A write sampled at rising edge k updates its register after edge k.
  - out_port reflects the update in the cycle following edge k; no further latency.
- Read timing:
  - readdata is registered, 1-cycle latency.
  - It updates every clock with mux(address), independent of chipselect.
  - Value after edge k = register contents before edge k's write takes effect; no write-through bypass.
- Pulse engine, states IDLE (pulse_cnt=0) / ACTIVE (pulse_cnt!=0):
  - pulse_busy = (pulse_cnt!=0).
  - out_port = data_reg ^ (pulse_mask & {DATA_WIDTH{pulse_busy}}).
  - IDLE -> ACTIVE: write N>0 to PULSE at edge k; pulse_cnt=N after edge k.
  - ACTIVE: pulse_cnt decrements by 1 each edge; masked bits stay inverted for exactly N cycles, then revert after edge k+N.
  - ACTIVE -> IDLE: pulse_cnt reaches 0.
- Boundary conditions:
  - PULSE write during ACTIVE restarts: pulse_cnt=new N. The write has priority over decrement, including on the final-count edge.
  - PULSE write of 0: immediate abort; IDLE after that edge, out_port=data_reg next cycle.
  - N = 2^CNT_WIDTH-1: no wrap; the counter never decrements below 0.
  - DATA/SET/CLR/TOGGLE writes during ACTIVE change the base value; the inversion continues on top.
  - MASK write during ACTIVE takes effect on the next cycle; the remaining count is unaffected.
  - Reset mid-pulse: the pulse is aborted and out_port=RESET_VALUE immediately (asynchronous).
- All outputs come straight from flops or a single XOR/AND level; no combinational path from bus inputs to out_port.

Test Plan:
1. Reset and DATA write:
   - Assert reset_n=0 -> out_port=0x0000, readdata=0, pulse_busy=0.
   - Release reset, write DATA=0xFFFF_A5A5 -> out_port=0xA5A5.
   - Read addr 0 -> readdata=0x0000_A5A5 one cycle later.
2. Atomic ops:
   - From 0xA5A5, SET 0x000F -> 0xA5AF.
   - CLR 0xA000 -> 0x05AF.
   - TOGGLE 0x00FF -> 0x0550.
   - Reads of addr 1, 2, 3 -> 0.
3. Pulse:
   - DATA=0x0000, MASK=0x0001, PULSE=5 at edge k -> out_port=0x0001 and pulse_busy=1 for exactly 5 cycles, then 0x0000 and busy=0.
   - Addr 5 reads count down 5, 4, 3, 2, 1, 0.
4. Restart/abort:
   - During a pulse of 10, at remaining=2 write PULSE=4 -> 4 more inverted cycles.
   - Separately, mid-pulse write PULSE=0 -> out_port reverts next cycle, STATUS=0.
5. Concurrency and reset:
   - During a pulse, write DATA=0x00F0 -> out_port=0x00F1 until expiry, then 0x00F0.
   - Assert reset_n mid-pulse -> out_port=0x0000, pulse_busy=0 immediately.
6. Width:
   - Write PULSE=0xFF00_0003 with CNT_WIDTH=24 -> count 3.
   - Write addr 7 -> no register changes; read addr 7 -> 0.
